// File: rtl/round_robin_distributor.sv
// Round-robin distributor: a 2-entry FIFO whose entries are tagged with a rotating
// channel index at enqueue time; the head entry is offered only to its own channel.
module round_robin_distributor #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 4,
  localparam int DEST_W = (SIZE > 2) ? $clog2(SIZE) : 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              upstream_valid,
  output logic              upstream_ready,
  input  logic [WIDTH-1:0]  upstream_data,
  output logic [SIZE-1:0]   downstream_valid,
  input  logic [SIZE-1:0]   downstream_ready,
  output logic [WIDTH-1:0]  downstream_data,
  output logic [DEST_W-1:0] destination
);

  logic [1:0]        count_q;
  logic [DEST_W-1:0] ptr_q;
  logic              rd_idx_q;
  logic              wr_idx_q;
  logic [WIDTH-1:0]  fifo_data [0:1];
  logic [DEST_W-1:0] fifo_dest [0:1];

  logic              push;
  logic              pop;
  logic              not_empty;
  logic [DEST_W-1:0] head_dest;

  assign not_empty       = (count_q != 2'd0);
  assign head_dest       = fifo_dest[rd_idx_q];
  assign upstream_ready  = (count_q != 2'd2);
  assign downstream_data = fifo_data[rd_idx_q];
  assign destination     = not_empty ? head_dest : '0;

  always_comb begin
    downstream_valid = '0;
    for (int i = 0; i < SIZE; i++) begin
      downstream_valid[i] = not_empty && (head_dest == DEST_W'(i));
    end
  end

  // Only the head's own channel can complete a pop; other ready bits are masked out.
  assign push = upstream_valid && upstream_ready;
  assign pop  = |(downstream_valid & downstream_ready);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q  <= 2'd0;
      ptr_q    <= '0;
      rd_idx_q <= 1'b0;
      wr_idx_q <= 1'b0;
    end else begin
      if (push) begin
        wr_idx_q <= ~wr_idx_q;
        ptr_q    <= (ptr_q == DEST_W'(SIZE - 1)) ? '0 : ptr_q + DEST_W'(1);
      end
      if (pop) begin
        rd_idx_q <= ~rd_idx_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_idx_q] <= upstream_data;
      fifo_dest[wr_idx_q] <= ptr_q;
    end
  end

endmodule

// File: doc/round_robin_distributor.md
ROUND_ROBIN_DISTRIBUTOR -- requirements
Module: round_robin_distributor

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 Parameter SIZE, default 4, number of downstream channels (>=2).
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port resetn  input  1  synchronous, active-low reset.
REQ-005 Port upstream_valid  input  1  upstream beat present.
REQ-006 Port upstream_ready  output  1  block can accept a beat this cycle.
REQ-007 Port upstream_data  input  WIDTH  upstream payload.
REQ-008 Port downstream_valid  output  SIZE  one-hot-or-zero; bit i = beat offered to channel i.
REQ-009 Port downstream_ready  input  SIZE  bit i = channel i accepts.
REQ-010 Port downstream_data  output  WIDTH  payload of head beat, shared by all channels.
REQ-011 Port destination  output  clog2(SIZE) (min 1)  index of the channel owning the head beat; 0 when empty.

Function
REQ-012 Block SHALL distribute upstream beats to channels in strict round-robin order 0,1,...,SIZE-1,0,... regardless of downstream readiness.
REQ-013 Block SHALL hold a 2-entry FIFO; each entry stores payload plus destination index.
REQ-014 Upstream transfer SHALL occur when upstream_valid and upstream_ready are both 1 at a rising edge.
REQ-015 upstream_ready SHALL be 1 exactly when occupancy < 2, driven from registered state only (no combinational path from any input).
REQ-016 On each upstream transfer the entry SHALL be tagged with the current pointer value, and the pointer SHALL advance by 1, wrapping from SIZE-1 to 0 (SIZE need not be a power of 2).
REQ-017 Pointer SHALL not change on cycles without an upstream transfer.
REQ-018 When occupancy > 0, downstream_valid SHALL equal a one-hot bit at the head entry's destination and downstream_data SHALL equal the head payload; otherwise downstream_valid SHALL be 0.
REQ-019 Downstream transfer SHALL occur when downstream_valid[d] and downstream_ready[d] are both 1 at a rising edge (d = head destination); readiness on other channels SHALL be ignored.
REQ-020 Once asserted, downstream_valid and downstream_data SHALL stay stable until the transfer completes (head blocking; no reordering, no bypass of a stalled channel).
REQ-021 Latency SHALL be 1 cycle: a beat accepted into an empty FIFO at edge N is offered from edge N onward (visible in the following cycle).
REQ-022 Simultaneous upstream and downstream transfer SHALL leave occupancy unchanged and preserve order; at occupancy 1 the new beat becomes head after the pop.
REQ-023 At occupancy 2, upstream_valid SHALL be ignored and pointer SHALL hold.
REQ-024 At occupancy 0, downstream_ready SHALL have no effect.
REQ-025 Full throughput SHALL be sustained: with continuous upstream_valid and all channels ready, one beat per cycle in both directions.
REQ-026 Overflow or underflow of occupancy SHALL be impossible by construction.

Reset
REQ-027 While resetn is 0 at a rising edge: occupancy SHALL become 0, pointer 0, stored entries discarded.
REQ-028 After reset edge: upstream_ready = 1, downstream_valid = 0, destination = 0; downstream_data value is don't-care.
REQ-029 Reset asserted mid-operation SHALL drop all buffered beats without emitting them and restart distribution at channel 0.

Verification
REQ-030 Single beat: reset, send 0xA5 with all ready -> downstream_valid=0001, data 0xA5 one cycle later, then valid 0.
REQ-031 Ordering: SIZE=4, send 0x10..0x17 continuously, all ready -> channels 0,1,2,3,0,1,2,3 receive 0x10..0x17 in order, one per cycle, upstream_ready never low.
REQ-032 Stall: downstream_ready=1101 (channel 1 stalled), send 6 beats -> beat 0 to ch0, beat 1 held on ch1, FIFO fills, upstream_ready=0 after 2 buffered; release ch1 -> remaining beats delivered to 1,2,3,0,1 in order, valid stable throughout stall.
REQ-033 Wrap with SIZE=3: send 7 beats -> destinations 0,1,2,0,1,2,0; pointer never reaches 3.
REQ-034 Reset mid-flight: fill FIFO (2 beats, ch0 stalled), assert resetn=0 one cycle -> downstream_valid=0, upstream_ready=1; next beat goes to channel 0.
REQ-035 Random: 1000 cycles random upstream_valid and downstream_ready -> scoreboard confirms every accepted beat delivered exactly once, in order, to index (accept_count mod SIZE); downstream_valid always one-hot or zero.
